// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl: bit-serial adder, LSB first, one full-adder cell.
// {cout,sum} = a + b + cin, result available WIDTH+1 edges after start.
// Optional macro SERIAL_ADDER_SUB_EN adds a 'sub' input for a - b.
//
// state | meaning
// IDLE  | waiting for start; operands latched on the accepting edge
// SHIFT | one operand bit processed per cycle, WIDTH cycles
// DONE  | result copied to sum/cout; done pulses on the following cycle
module serial_adder_ctrl #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
   input  logic             sub,
`endif
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] opa_q, opa_d;
   logic [WIDTH-1:0] opb_q, opb_d;
   logic [WIDTH-1:0] res_q, res_d;
   logic [WIDTH-1:0] sum_q, sum_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             carry_q, carry_d;
   logic             cout_q, cout_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;

   logic [WIDTH-1:0] b_eff;
   logic             cin_eff;
   logic             fa_s;
   logic             fa_c;

`ifdef SERIAL_ADDER_SUB_EN
   // Subtraction is a + ~b + 1, so only the latched operand and carry-in differ.
   assign b_eff   = sub ? ~b : b;
   assign cin_eff = sub ? 1'b1 : cin;
`else
   assign b_eff   = b;
   assign cin_eff = cin;
`endif

   assign fa_s = opa_q[0] ^ opb_q[0] ^ carry_q;
   assign fa_c = (opa_q[0] & opb_q[0]) | (carry_q & (opa_q[0] ^ opb_q[0]));

   // Next-state, datapath and output decode.
   always_comb begin
      state_d = state_q;
      opa_d   = opa_q;
      opb_d   = opb_q;
      res_d   = res_q;
      carry_d = carry_q;
      cnt_d   = cnt_q;
      sum_d   = sum_q;
      cout_d  = cout_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               state_d = SHIFT;
               opa_d   = a;
               opb_d   = b_eff;
               carry_d = cin_eff;
               cnt_d   = '0;
            end
         end
         SHIFT: begin
            opa_d   = opa_q >> 1;
            opb_d   = opb_q >> 1;
            res_d   = {fa_s, res_q[WIDTH-1:1]};
            carry_d = fa_c;
            // Counter stops at the last bit rather than wrapping.
            if (cnt_q == LAST) begin
               state_d = DONE;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         DONE: begin
            sum_d   = res_q;
            cout_d  = carry_q;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      busy_d = (state_d == SHIFT);
      done_d = (state_q == DONE);
   end

   // State and datapath registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         opa_q   <= '0;
         opb_q   <= '0;
         res_q   <= '0;
         carry_q <= 1'b0;
         cnt_q   <= '0;
         sum_q   <= '0;
         cout_q  <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         opa_q   <= opa_d;
         opb_q   <= opb_d;
         res_q   <= res_d;
         carry_q <= carry_d;
         cnt_q   <= cnt_d;
         sum_q   <= sum_d;
         cout_q  <= cout_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign busy = busy_q;
   assign done = done_q;
   assign sum  = sum_q;
   assign cout = cout_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed bench for serial_adder_ctrl at WIDTH=8.
module tb_serial_adder_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic [7:0] a, b;
   logic       cin;
   logic       sub;
   logic       busy, done, cout;
   logic [7:0] sum;

   int n_checks = 0;
   int n_fail   = 0;

   serial_adder_ctrl #(.WIDTH(8)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .a     (a),
      .b     (b),
      .cin   (cin),
`ifdef SERIAL_ADDER_SUB_EN
      .sub   (sub),
`endif
      .busy  (busy),
      .done  (done),
      .sum   (sum),
      .cout  (cout)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One operation: operands scrambled while busy; optional ignored start in 3rd SHIFT cycle.
   task automatic run_op(input string tag, input logic [7:0] ia, input logic [7:0] ib,
                         input logic icin, input logic isub, input logic [7:0] es,
                         input logic ec, input bit ign);
      int n;
      int nb;
      a = ia; b = ib; cin = icin; sub = isub; start = 1'b1;
      step();
      start = 1'b0; a = ~ia; b = ia ^ ib ^ 8'h5C; cin = ~icin; sub = ~isub;
      n  = 0;
      nb = busy ? 1 : 0;
      while (!done && n < 40) begin
         if (ign && n == 2) begin
            start = 1'b1; a = 8'hFF; b = 8'hFF; cin = 1'b1;
         end
         step();
         start = 1'b0;
         n++;
         if (busy) nb++;
      end
      check({tag, "_latency"}, n, 9);
      check({tag, "_busy_cycles"}, nb, 8);
      check({tag, "_sum"}, sum, es);
      check({tag, "_cout"}, cout, ec);
      step();
      check({tag, "_done_single"}, done, 1'b0);
      check({tag, "_sum_hold"}, sum, es);
      if (ign) check({tag, "_no_second_op"}, busy, 1'b0);
   endtask

   initial begin
      int         nd;
      int         didx[$];
      logic [7:0] rsum[$];
      logic       rcout[$];
      logic [8:0] exp_q[$];
      logic [8:0] t;

      rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
      step();
      step();
      check("rst_busy", busy, 1'b0);
      check("rst_done", done, 1'b0);
      check("rst_sum", sum, 8'h00);
      check("rst_cout", cout, 1'b0);
      rst = 1'b0;
      step();

      run_op("add_5a_33", 8'h5A, 8'h33, 1'b0, 1'b0, 8'h8D, 1'b0, 1'b0);
      run_op("add_ff_01", 8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
      run_op("add_ff_ff_c", 8'hFF, 8'hFF, 1'b1, 1'b0, 8'hFF, 1'b1, 1'b0);
      run_op("add_80_80_c", 8'h80, 8'h80, 1'b1, 1'b0, 8'h01, 1'b1, 1'b0);
      run_op("ignore_start", 8'h12, 8'h34, 1'b1, 1'b0, 8'h47, 1'b0, 1'b1);

      // Reset during the 4th SHIFT cycle aborts without a done pulse.
      a = 8'hC3; b = 8'h3C; cin = 1'b0; start = 1'b1;
      step();
      start = 1'b0;
      step(); step(); step();
      rst = 1'b1;
      step();
      check("abort_busy", busy, 1'b0);
      check("abort_done", done, 1'b0);
      check("abort_sum", sum, 8'h00);
      check("abort_cout", cout, 1'b0);
      rst = 1'b0;
      nd = 0;
      for (int i = 0; i < 15; i++) begin
         step();
         if (done) nd++;
      end
      check("abort_no_done", nd, 0);
      run_op("after_abort", 8'h01, 8'h01, 1'b0, 1'b0, 8'h02, 1'b0, 1'b0);

      // start held for 25 cycles with operands changing every cycle.
      for (int k = 0; k < 40; k++) begin
         if (k < 25) begin
            start = 1'b1;
            a     = 8'(k * 37 + 5);
            b     = 8'(k * 91 + 17);
            cin   = k[0];
            if (k % 10 == 0) exp_q.push_back(9'(a) + 9'(b) + 9'(cin));
         end else begin
            start = 1'b0;
         end
         step();
         if (done) begin
            didx.push_back(k);
            rsum.push_back(sum);
            rcout.push_back(cout);
         end
      end
      check("b2b_done_count", didx.size(), 3);
      for (int i = 0; i < 3; i++) begin
         t = exp_q[i];
         check($sformatf("b2b_idx%0d", i), (i < didx.size()) ? didx[i] : -1, 9 + 10 * i);
         check($sformatf("b2b_sum%0d", i), (i < rsum.size()) ? rsum[i] : 8'hxx, t[7:0]);
         check($sformatf("b2b_cout%0d", i), (i < rcout.size()) ? rcout[i] : 1'bx, t[8]);
      end

`ifdef SERIAL_ADDER_SUB_EN
      run_op("sub_10_01", 8'h10, 8'h01, 1'b0, 1'b1, 8'h0F, 1'b1, 1'b0);
      run_op("sub_01_02", 8'h01, 8'h02, 1'b0, 1'b1, 8'hFF, 1'b0, 1'b0);
      run_op("sub0_add", 8'h5A, 8'h33, 1'b0, 1'b0, 8'h8D, 1'b0, 1'b0);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/serial_adder_ctrl.md
SERIAL_ADDER_CTRL -- requirements
Module: serial_adder_ctrl

Interface
REQ-001 The block SHALL have one clock; reset is synchronous and active-high.
REQ-002 Parameter WIDTH, default 8, operand/result width in bits; legal range 2..64.
REQ-003 Port clk  input  1  rising-edge clock for all state.
REQ-004 Port rst  input  1  synchronous active-high reset.
REQ-005 Port start  input  1  request to begin an addition; sampled each rising edge.
REQ-006 Port a  input  WIDTH  operand A; sampled only on the start-accepting edge.
REQ-007 Port b  input  WIDTH  operand B; sampled only on the start-accepting edge.
REQ-008 Port cin  input  1  carry-in; sampled only on the start-accepting edge.
REQ-009 Port busy  output  1  high while an operation is in progress.
REQ-010 Port done  output  1  single-cycle completion pulse.
REQ-011 Port sum  output  WIDTH  registered result of the last completed operation.
REQ-012 Port cout  output  1  registered carry-out of the last completed operation.

Function
REQ-013 The block SHALL compute {cout,sum} = a + b + cin bit-serially, LSB first, with a single 1-bit full-adder cell (sum = x^y^c, carry = x&y | c&(x^y)) and a 1-bit carry register.
REQ-014 The state machine SHALL have the states IDLE, SHIFT and DONE.
REQ-015 IDLE -> SHIFT when start=1: latch a and b into shift registers, load cin into the carry register, clear the bit counter, and set busy=1 from the next cycle.
REQ-016 Each SHIFT cycle SHALL add the operand LSBs plus carry, shift the result bit into the result shift register from the MSB side, shift both operands right by one, update carry, and increment the bit counter.
REQ-017 SHIFT -> DONE on the edge that processes bit WIDTH-1; the counter is $clog2(WIDTH) bits and SHALL NOT wrap during an operation.
REQ-018 In DONE: sum and cout SHALL be loaded from the result register and carry, done=1 and busy=0 for exactly one cycle, then the machine returns to IDLE.
REQ-019 Latency: done SHALL be visible in the cycle beginning WIDTH+1 rising edges after the start-accepting edge; busy SHALL be high for exactly WIDTH cycles.
REQ-020 start in SHIFT or DONE SHALL be ignored with no effect on the operation in flight; start in the IDLE cycle immediately after DONE SHALL be accepted, so back-to-back throughput is one result per WIDTH+2 cycles.
REQ-021 Changes on a, b or cin while busy=1 SHALL NOT affect the result.
REQ-022 sum and cout SHALL hold their value from the end of one DONE until the next DONE and SHALL change at no other time except reset.

Reset
REQ-023 rst=1 on a rising edge SHALL force state IDLE and busy=0, done=0, sum=0, cout=0, and clear the carry, counter and shift registers; this takes priority over start.
REQ-024 Reset asserted mid-SHIFT SHALL abort the operation with no done pulse; the first start after rst deasserts SHALL run a complete, correct operation.

Configuration
REQ-025 Macro SERIAL_ADDER_SUB_EN: when defined, an extra port sub (input, 1 bit, sampled on the start-accepting edge) SHALL exist; sub=1 latches ~b and forces the carry-in to 1 (cin ignored), giving sum = a - b and cout = 1 when there is no borrow; sub=0 behaves as plain addition.
REQ-026 When SERIAL_ADDER_SUB_EN is undefined, the sub port and its logic SHALL be absent and the block SHALL perform addition only.

Verification (WIDTH=8)
REQ-027 a=0x5A, b=0x33, cin=0, start pulse -> busy for 8 cycles, done 9 edges after start, sum=0x8D, cout=0.
REQ-028 a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1; a=0xFF, b=0xFF, cin=1 -> sum=0xFF, cout=1.
REQ-029 start held high continuously for 25 cycles with changing operands -> one result per 10 cycles; each result matches the operands sampled on its accepting edge; exactly one done per operation.
REQ-030 start pulsed again at the 3rd SHIFT cycle -> ignored; single done; result matches the first operands.
REQ-031 rst asserted during the 4th SHIFT cycle -> next cycle busy=0, done=0, sum=0x00, cout=0, no done pulse; a following start with a=0x01, b=0x01 gives sum=0x02.
REQ-032 With SERIAL_ADDER_SUB_EN defined: sub=1, a=0x10, b=0x01 -> sum=0x0F, cout=1; sub=1, a=0x01, b=0x02 -> sum=0xFF, cout=0.
